// File: rtl/uart_frame_assembler.sv
// Packs UART bytes MSB-first into frames and buffers them in a show-ahead FIFO.
// Frame written at the edge of its last byte, visible next cycle; no upstream back-pressure, full FIFO drops new frames.

module frame_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   not_empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push && (!full || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

module uart_frame_assembler #(
  parameter int BYTES_PER_FRAME = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int CNT_W           = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         rx_byte,
  input  logic                               rx_byte_valid,
  output logic [8*BYTES_PER_FRAME-1:0]       frame_value,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [$clog2(BYTES_PER_FRAME):0]   partial_bytes,
  output logic                               overflow,
  output logic [CNT_W-1:0]                   drop_count,
  output logic [CNT_W-1:0]                   timeout_count,
  input  logic                               clear_status
);
  localparam int FRAME_W  = 8 * BYTES_PER_FRAME;
  localparam int PB_W     = $clog2(BYTES_PER_FRAME) + 1;
  localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TMO_EN   = (TIMEOUT_CYCLES > 0);

  typedef enum logic {COLLECT_IDLE, COLLECT} state_t;

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_next;
  logic [TMR_W-1:0]   timer;
  logic               last_byte;
  logic               timeout_hit;
  logic               pop;
  logic               full;
  logic               drop;

  assign frame_next  = FRAME_W'({shreg, rx_byte});
  assign last_byte   = rx_byte_valid && (partial_bytes == PB_W'(BYTES_PER_FRAME - 1));
  // Expires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = TMO_EN && (state == COLLECT) && !rx_byte_valid &&
                       (timer == TMR_W'(TMO_LAST));
  assign pop         = frame_valid && frame_ready;
  assign drop        = last_byte && full && !pop;

  frame_fifo #(.W(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (last_byte),
    .push_data (frame_next),
    .pop       (pop),
    .head      (frame_value),
    .not_empty (frame_valid),
    .full      (full),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= COLLECT_IDLE;
      partial_bytes <= '0;
      shreg         <= '0;
      timer         <= '0;
    end else if (rx_byte_valid) begin
      timer <= '0;
      shreg <= frame_next;
      if (last_byte) begin
        partial_bytes <= '0;
        state         <= COLLECT_IDLE;
      end else begin
        partial_bytes <= partial_bytes + 1'b1;
        state         <= COLLECT;
      end
    end else if (timeout_hit) begin
      partial_bytes <= '0;
      state         <= COLLECT_IDLE;
      timer         <= '0;
    end else if (state == COLLECT && TMO_EN) begin
      timer <= timer + 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A same-cycle event wins over clear_status, leaving the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow      <= 1'b0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;

      if (drop)              drop_count <= clear_status ? CNT_W'(1) : sat_inc(drop_count);
      else if (clear_status) drop_count <= '0;

      if (timeout_hit)       timeout_count <= clear_status ? CNT_W'(1) : sat_inc(timeout_count);
      else if (clear_status) timeout_count <= '0;
    end
  end
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_uart_frame_assembler;
  localparam int BPF   = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 10;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [63:0] frame_value;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  fifo_level;
  logic [3:0]  partial_bytes;
  logic        overflow;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] timeout_count;
  logic        clear_status;

  always #5 clk = ~clk;

  uart_frame_assembler #(
    .BYTES_PER_FRAME(BPF), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .frame_value(frame_value), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .fifo_level(fifo_level), .partial_bytes(partial_bytes), .overflow(overflow),
    .drop_count(drop_count), .timeout_count(timeout_count), .clear_status(clear_status)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending bytes, buffered frames, idle-cycle count, status.
  logic [7:0]  pq[$];
  logic [63:0] fq[$];
  logic [63:0] popped[$];
  int idle, m_drop, m_tmo;
  bit m_ov;

  typedef struct {
    bit          v;
    logic [7:0]  b;
    bit          rdy;
    bit          exp_valid;
    logic [63:0] exp_value;
    int          exp_level;
    int          exp_partial;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete(); fq.delete();
    idle = 0; m_ov = 0; m_drop = 0; m_tmo = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
    bit pop, complete, tmo, drop;
    logic [63:0] val;
    pop      = (fq.size() > 0) && rdy;
    complete = v && (pq.size() == BPF - 1);
    tmo      = !v && (pq.size() > 0) && (idle + 1 == TMO);
    drop     = 1'b0;
    if (pop) void'(fq.pop_front());
    if (complete) begin
      val = 64'h0;
      foreach (pq[i]) val = (val << 8) | 64'(pq[i]);
      val = (val << 8) | 64'(b);
      if (fq.size() < DEPTH) fq.push_back(val);
      else drop = 1'b1;
    end
    if (v) begin
      if (complete) pq.delete();
      else pq.push_back(b);
      idle = 0;
    end else if (tmo) begin
      pq.delete();
      idle = 0;
    end else if (pq.size() > 0) begin
      idle++;
    end
    if (drop) begin
      m_ov = 1'b1;
      m_drop = clr ? 1 : ((m_drop < CMAX) ? m_drop + 1 : m_drop);
    end else if (clr) begin
      m_ov = 1'b0; m_drop = 0;
    end
    if (tmo) m_tmo = clr ? 1 : ((m_tmo < CMAX) ? m_tmo + 1 : m_tmo);
    else if (clr) m_tmo = 0;
  endtask

  task automatic compare_model();
    chk("m_valid", frame_valid, fq.size() > 0);
    if (fq.size() > 0) chk("m_value", frame_value, fq[0]);
    chk("m_level", fifo_level, fq.size());
    chk("m_partial", partial_bytes, pq.size());
    chk("m_overflow", overflow, m_ov);
    chk("m_drop", drop_count, m_drop);
    chk("m_timeout", timeout_count, m_tmo);
  endtask

  // Check current outputs, drive one cycle of inputs, advance model and clock.
  task automatic cycle(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
    compare_model();
    if (frame_valid && rdy) popped.push_back(frame_value);
    rx_byte_valid = v; rx_byte = b; frame_ready = rdy; clear_status = clr;
    model_step(v, b, rdy, clr);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_byte_valid = 1'b0; rx_byte = 8'h0; frame_ready = 1'b0; clear_status = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_valid", frame_valid, 0);
    chk("rst_value", frame_value, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_partial", partial_bytes, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_timeout", timeout_count, 0);
  endtask

  task automatic send_frame(input logic [63:0] f, input bit rdy_mid, input bit rdy_last, input bit clr_last);
    for (int i = 0; i < BPF; i++)
      cycle(1'b1, f[63-8*i -: 8], (i == BPF-1) ? rdy_last : rdy_mid, (i == BPF-1) ? clr_last : 1'b0);
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0);
  endtask

  function automatic logic [63:0] mkf(input int k);
    logic [63:0] f = 64'h0;
    for (int j = 0; j < BPF; j++) f = (f << 8) | 64'(((k & 15) << 4) | j);
    return f;
  endfunction

  initial begin
    int dens, rdens;
    bit v, rdy, clr;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{v: 1'b1, b: 8'(i + 1), rdy: 1'b1, exp_valid: 1'b0, exp_value: 64'h0,
                 exp_level: 0, exp_partial: i};
    tbl[8] = '{v: 1'b0, b: 8'h00, rdy: 1'b1, exp_valid: 1'b1, exp_value: 64'h0102030405060708,
               exp_level: 1, exp_partial: 0};
    tbl[9] = '{v: 1'b0, b: 8'h00, rdy: 1'b1, exp_valid: 1'b0, exp_value: 64'h0,
               exp_level: 0, exp_partial: 0};

    do_reset();

    foreach (tbl[i]) begin
      chk("tbl_valid", frame_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_value", frame_value, tbl[i].exp_value);
      chk("tbl_level", fifo_level, tbl[i].exp_level);
      chk("tbl_partial", partial_bytes, tbl[i].exp_partial);
      cycle(tbl[i].v, tbl[i].b, tbl[i].rdy, 1'b0);
    end

    // Bytes three cycles apart still form one frame.
    popped.delete();
    for (int i = 0; i < BPF; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b1, 1'b0);
      if (i < BPF - 1) idle_cycles(2, 1'b1);
    end
    idle_cycles(3, 1'b1);
    chk("spaced_count", popped.size(), 1);
    if (popped.size() > 0) chk("spaced_value", popped[0], 64'h0102030405060708);
    chk("spaced_timeout", timeout_count, 0);

    // Ten idle cycles after a partial frame discard it.
    popped.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 1), 1'b1, 1'b0);
    idle_cycles(9, 1'b1);
    chk("tmo_before", partial_bytes, 3);
    idle_cycles(1, 1'b1);
    chk("tmo_partial", partial_bytes, 0);
    chk("tmo_count", timeout_count, 1);
    send_frame(64'h1112131415161718, 1'b1, 1'b1, 1'b0);
    idle_cycles(3, 1'b1);
    chk("tmo_frames", popped.size(), 1);
    if (popped.size() > 0) chk("tmo_value", popped[0], 64'h1112131415161718);

    // A byte on the expiry cycle continues the frame.
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_timeout", timeout_count, 0);
    popped.delete();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h21 + i), 1'b1, 1'b0);
    idle_cycles(9, 1'b1);
    cycle(1'b1, 8'h28, 1'b1, 1'b0);
    idle_cycles(3, 1'b1);
    chk("exp_timeout", timeout_count, 0);
    chk("exp_frames", popped.size(), 1);
    if (popped.size() > 0) chk("exp_value", popped[0], 64'h2122232425262728);

    // Overflow: fifth frame dropped, first four drain in order.
    popped.delete();
    for (int k = 0; k < 5; k++) send_frame(mkf(k), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 1);
    idle_cycles(6, 1'b1);
    chk("ovf_drained", popped.size(), 4);
    for (int k = 0; k < 4; k++) if (k < popped.size()) chk("ovf_order", popped[k], mkf(k));
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovf_clr_flag", overflow, 0);
    chk("ovf_clr_drop", drop_count, 0);

    // Full FIFO with a pop in the completion cycle keeps the new frame.
    popped.delete();
    for (int k = 10; k < 14; k++) send_frame(mkf(k), 1'b0, 1'b0, 1'b0);
    send_frame(mkf(14), 1'b0, 1'b1, 1'b0);
    chk("pp_level", fifo_level, 4);
    chk("pp_drop", drop_count, 0);
    chk("pp_overflow", overflow, 0);
    idle_cycles(6, 1'b1);
    chk("pp_count", popped.size(), 5);
    for (int k = 0; k < 5; k++) if (k < popped.size()) chk("pp_order", popped[k], mkf(10 + k));

    // Drop counter saturates; a drop coinciding with clear leaves one.
    for (int k = 0; k < 13; k++) send_frame(mkf(k), 1'b0, 1'b0, 1'b0);
    chk("sat_drop", drop_count, CMAX);
    send_frame(mkf(13), 1'b0, 1'b0, 1'b1);
    chk("clr_race_drop", drop_count, 1);
    chk("clr_race_flag", overflow, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    idle_cycles(5, 1'b1);

    // Reset with buffered frames and a partial frame, then a clean frame.
    send_frame(mkf(1), 1'b0, 1'b0, 1'b0);
    send_frame(mkf(2), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    do_reset();
    popped.delete();
    send_frame(mkf(5), 1'b1, 1'b1, 1'b0);
    idle_cycles(3, 1'b1);
    chk("post_rst_count", popped.size(), 1);
    if (popped.size() > 0) chk("post_rst_value", popped[0], mkf(5));

    // Random traffic with varying byte density and consumer readiness.
    dens = 5; rdens = 5;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        dens  = $urandom_range(1, 10);
        rdens = $urandom_range(0, 10);
      end
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        v   = ($urandom_range(0, 9) < dens);
        rdy = ($urandom_range(0, 9) < rdens);
        clr = ($urandom_range(0, 99) == 0);
        cycle(v, 8'($urandom), rdy, clr);
      end
    end
    compare_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
